// File: rtl/ct_fcnvt_ftoi_rnd.sv
// Float-to-integer round/saturate stage: S1 applies the rounding increment to the
// aligned magnitude, S2 range-checks, saturates or negates, and registers result + NV/NX.
module ct_fcnvt_ftoi_rnd (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        pipe_flush,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [63:0] in_v,
  input  logic [53:0] in_x,
  input  logic        in_sign,
  input  logic [2:0]  in_rm,
  input  logic [1:0]  in_dtype,
  input  logic        in_nan,
  input  logic        in_inf,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [63:0] out_result,
  output logic        out_nv,
  output logic        out_nx
);

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef enum logic [1:0] {
    DT_W  = 2'd0,
    DT_WU = 2'd1,
    DT_L  = 2'd2,
    DT_LU = 2'd3
  } dtype_e;

  // ---------------------------------------------------------------- handshake
  logic s1_vld_q;
  logic s2_vld_q;
  logic s2_adv;
  logic s1_load;

  assign s2_adv  = !s2_vld_q || out_rdy;
  assign in_rdy  = !s1_vld_q || s2_adv;
  assign s1_load = in_vld && in_rdy && !pipe_flush;

  // ---------------------------------------------------------------- S1 rounding
  logic        g;
  logic        s;
  logic        inc;
  logic [64:0] m_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    g   = in_x[53];
    s   = |in_x[52:0];
    inc = 1'b0;
    case (in_rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = in_sign && (g || s);
      RM_RUP:  inc = !in_sign && (g || s);
      RM_RMM:  inc = g;
      default: inc = g && (s || in_v[0]);  // RNE, and the reserved encodings 5-7
    endcase
    m_d = {1'b0, in_v} + {64'd0, inc};
  end

  logic [64:0] s1_m_q;
  logic        s1_sign_q;
  dtype_e      s1_dtype_q;
  logic        s1_nan_q;
  logic        s1_inf_q;
  logic        s1_gs_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst || pipe_flush) begin
      s1_vld_q <= 1'b0;
    end else if (in_rdy) begin
      s1_vld_q <= in_vld;
    end
  end

  // NOTE: payload registers carry no reset; the valid bit alone says whether they mean anything.
  always_ff @(posedge forever_cpuclk) begin
    if (s1_load) begin
      s1_m_q     <= m_d;
      s1_sign_q  <= in_sign;
      s1_dtype_q <= dtype_e'(in_dtype);
      s1_nan_q   <= in_nan;
      s1_inf_q   <= in_inf;
      s1_gs_q    <= |in_x;
    end
  end

  // ---------------------------------------------------------------- S2 range / saturate
  logic [63:0] pos_sat;
  logic [63:0] neg_sat;
  logic        ovf;
  logic [63:0] mag_res;
  logic [63:0] int_res;
  logic [63:0] result_d;
  logic        nv_d;
  logic        nx_d;

  always_comb begin
    pos_sat = '1;
    neg_sat = '0;
    ovf     = 1'b0;
    case (s1_dtype_q)
      DT_W: begin
        pos_sat = 64'h0000_0000_7FFF_FFFF;
        neg_sat = 64'hFFFF_FFFF_8000_0000;
        ovf     = s1_sign_q ? (s1_m_q > 65'h0_0000_0000_8000_0000)
                            : (s1_m_q > 65'h0_0000_0000_7FFF_FFFF);
      end
      DT_WU: begin
        pos_sat = '1;
        neg_sat = '0;
        ovf     = s1_sign_q ? (s1_m_q != 65'd0)
                            : (s1_m_q > 65'h0_0000_0000_FFFF_FFFF);
      end
      DT_L: begin
        pos_sat = 64'h7FFF_FFFF_FFFF_FFFF;
        neg_sat = 64'h8000_0000_0000_0000;
        ovf     = s1_sign_q ? (s1_m_q > 65'h0_8000_0000_0000_0000)
                            : (s1_m_q > 65'h0_7FFF_FFFF_FFFF_FFFF);
      end
      default: begin
        pos_sat = '1;
        neg_sat = '0;
        ovf     = s1_sign_q ? (s1_m_q != 65'd0) : s1_m_q[64];
      end
    endcase

    mag_res = s1_sign_q ? (64'd0 - s1_m_q[63:0]) : s1_m_q[63:0];
    // 32-bit destinations are returned sign-extended from bit 31, even for WU.
    if (s1_dtype_q == DT_W || s1_dtype_q == DT_WU) begin
      int_res = {{32{mag_res[31]}}, mag_res[31:0]};
    end else begin
      int_res = mag_res;
    end

    nv_d = s1_nan_q || s1_inf_q || ovf;
    nx_d = !nv_d && s1_gs_q;
    if (s1_nan_q) begin
      result_d = pos_sat;
    end else if (s1_inf_q || ovf) begin
      result_d = s1_sign_q ? neg_sat : pos_sat;
    end else begin
      result_d = int_res;
    end
  end

  logic [63:0] s2_result_q;
  logic        s2_nv_q;
  logic        s2_nx_q;

  // Output registers only load on an S1->S2 move, so a stalled result holds stable.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s2_vld_q    <= 1'b0;
      s2_result_q <= '0;
      s2_nv_q     <= 1'b0;
      s2_nx_q     <= 1'b0;
    end else begin
      if (pipe_flush) begin
        s2_vld_q <= 1'b0;
      end else if (s2_adv) begin
        s2_vld_q <= s1_vld_q;
      end
      if (s2_adv && s1_vld_q && !pipe_flush) begin
        s2_result_q <= result_d;
        s2_nv_q     <= nv_d;
        s2_nx_q     <= nx_d;
      end
    end
  end

  assign out_vld    = s2_vld_q;
  assign out_result = s2_result_q;
  assign out_nv     = s2_nv_q;
  assign out_nx     = s2_nx_q;

endmodule

// File: tb/tb_ct_fcnvt_ftoi_rnd.sv
// Directed bench for ct_fcnvt_ftoi_rnd: hand-derived expectations go into a scoreboard
// on input handshake and are compared when the DUT hands a result out.
module tb_ct_fcnvt_ftoi_rnd;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  logic        pipe_flush;
  logic        in_vld;
  logic        in_rdy;
  logic [63:0] in_v;
  logic [53:0] in_x;
  logic        in_sign;
  logic [2:0]  in_rm;
  logic [1:0]  in_dtype;
  logic        in_nan;
  logic        in_inf;
  logic        out_vld;
  logic        out_rdy;
  logic [63:0] out_result;
  logic        out_nv;
  logic        out_nx;

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_fcnvt_ftoi_rnd dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .pipe_flush     (pipe_flush),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .in_v           (in_v),
    .in_x           (in_x),
    .in_sign        (in_sign),
    .in_rm          (in_rm),
    .in_dtype       (in_dtype),
    .in_nan         (in_nan),
    .in_inf         (in_inf),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
    .out_result     (out_result),
    .out_nv         (out_nv),
    .out_nx         (out_nx)
  );

  localparam logic [53:0] HALF = 54'h20_0000_0000_0000;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [1:0] W = 2'd0, WU = 2'd1, L = 2'd2, LU = 2'd3;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] res;
    logic        nv;
    logic        nx;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   out_count    = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic send(input logic [63:0] v, input logic [53:0] x, input logic sign,
                      input logic [2:0] rm, input logic [1:0] dt, input logic nan,
                      input logic inf, input logic [63:0] er, input logic env,
                      input logic enx, input string tag);
    logic ok;
    ok       = 1'b0;
    in_v     = v;
    in_x     = x;
    in_sign  = sign;
    in_rm    = rm;
    in_dtype = dt;
    in_nan   = nan;
    in_inf   = inf;
    cur_exp  = '{er, env, enx, tag};
    in_vld   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge forever_cpuclk);
      if (in_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " accepted"}, 64'(ok), 64'd1);
    @(posedge forever_cpuclk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check({tag, " drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c0;
    cpurst     = 1'b1;
    pipe_flush = 1'b0;
    in_vld     = 1'b0;
    in_v       = '0;
    in_x       = '0;
    in_sign    = 1'b0;
    in_rm      = '0;
    in_dtype   = '0;
    in_nan     = 1'b0;
    in_inf     = 1'b0;
    out_rdy    = 1'b0;
    cur_exp    = '{64'd0, 1'b0, 1'b0, "idle"};
    c0         = 0;

    // Output-side scoreboard monitor, sampling on the falling edge.
    fork
      begin
        exp_t e;
        forever begin
          @(negedge forever_cpuclk);
          if (cpurst) begin
            sb.delete();
          end else begin
            if (out_vld && out_rdy) begin
              out_count++;
              if (sb.size() == 0) begin
                check("unexpected output", 64'(out_vld), 64'd0);
              end else begin
                e = sb.pop_front();
                check({e.tag, " result"}, out_result, e.res);
                check({e.tag, " nv"}, 64'(out_nv), 64'(e.nv));
                check({e.tag, " nx"}, 64'(out_nx), 64'(e.nx));
              end
            end
            if (pipe_flush) sb.delete();
            else if (in_vld && in_rdy) sb.push_back(cur_exp);
          end
        end
      end
    join_none

    repeat (3) tick();
    cpurst = 1'b0;
    check("reset out_vld", 64'(out_vld), 64'd0);
    check("reset out_result", out_result, 64'd0);
    check("reset out_nv", 64'(out_nv), 64'd0);
    check("reset out_nx", 64'(out_nx), 64'd0);
    check("reset in_rdy", 64'(in_rdy), 64'd1);

    // Directed conversions, streamed back to back.
    out_rdy = 1'b1;
    send(64'd2, HALF, 1'b0, RNE, W, 1'b0, 1'b0, 64'd2, 1'b0, 1'b1, "W RNE 2.5");
    send(64'd3, HALF, 1'b0, RNE, W, 1'b0, 1'b0, 64'd4, 1'b0, 1'b1, "W RNE 3.5");
    send(64'd2, HALF, 1'b1, RDN, W, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, "W RDN -2.5");
    send(64'h8000_0000, 54'd0, 1'b0, RNE, W, 1'b0, 1'b0, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0, "W pos ovf");
    send(64'h8000_0000, 54'd0, 1'b1, RNE, W, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, "W neg min");
    send(ONES, 54'd1, 1'b0, RUP, LU, 1'b0, 1'b0, ONES, 1'b1, 1'b0, "LU RUP carry");
    send(64'd0, HALF, 1'b1, RTZ, WU, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, "WU neg to zero");
    send(64'd5, 54'd0, 1'b0, RNE, L, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "L NaN");
    send(64'd0, 54'd0, 1'b1, RNE, W, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, "W -Inf");
    send(64'hFFFF_FFFF, 54'd0, 1'b0, RTZ, WU, 1'b0, 1'b0, ONES, 1'b0, 1'b0, "WU max");
    send(64'd1, 54'd0, 1'b1, RTZ, WU, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, "WU neg ovf");
    send(64'd5, HALF, 1'b1, RMM, L, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b1, "L RMM -5.5");
    send(64'd7, 54'd1, 1'b0, RUP, L, 1'b0, 1'b0, 64'd8, 1'b0, 1'b1, "L RUP sticky");
    send(64'd4, HALF, 1'b0, 3'd6, L, 1'b0, 1'b0, 64'd4, 1'b0, 1'b1, "L rm6 as RNE");
    send(64'h8000_0000_0000_0000, 54'd0, 1'b1, RTZ, L, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, "L neg min");
    send(64'd0, 54'd0, 1'b0, RNE, WU, 1'b0, 1'b1, ONES, 1'b1, 1'b0, "WU +Inf");
    send(64'd0, 54'd0, 1'b1, RNE, W, 1'b1, 1'b0, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0, "W neg NaN");
    send(64'd0, 54'd1, 1'b1, RDN, LU, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, "LU RDN neg ovf");
    drain("directed");

    // Stall: two entries held, the third waits for the consumer.
    out_rdy = 1'b0;
    send(64'd1, 54'd0, 1'b0, RNE, L, 1'b0, 1'b0, 64'd1, 1'b0, 1'b0, "stall e1");
    send(64'd2, 54'd0, 1'b0, RNE, L, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, "stall e2");
    check("stall in_rdy low", 64'(in_rdy), 64'd0);
    check("stall out_vld", 64'(out_vld), 64'd1);
    check("stall head", out_result, 64'd1);
    fork
      send(64'd3, 54'd0, 1'b0, RNE, L, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0, "stall e3");
      begin
        repeat (4) tick();
        check("stall hold", out_result, 64'd1);
        c0      = out_count;
        out_rdy = 1'b1;
      end
    join
    repeat (2) tick();
    check("stall consecutive outputs", 64'(out_count - c0), 64'd3);
    check("stall empty after", 64'(out_vld), 64'd0);

    // Flush with two entries in flight plus an offered entry.
    out_rdy = 1'b0;
    send(64'd10, 54'd0, 1'b0, RNE, L, 1'b0, 1'b0, 64'd10, 1'b0, 1'b0, "flush a");
    send(64'd11, 54'd0, 1'b0, RNE, L, 1'b0, 1'b0, 64'd11, 1'b0, 1'b0, "flush b");
    in_v       = 64'd12;
    cur_exp    = '{64'd12, 1'b0, 1'b0, "flush c"};
    in_vld     = 1'b1;
    pipe_flush = 1'b1;
    tick();
    pipe_flush = 1'b0;
    in_vld     = 1'b0;
    check("flush out_vld", 64'(out_vld), 64'd0);
    check("flush in_rdy", 64'(in_rdy), 64'd1);
    out_rdy = 1'b1;
    repeat (4) tick();
    check("flush no stale", 64'(out_vld), 64'd0);
    send(64'd42, 54'd0, 1'b0, RNE, L, 1'b0, 1'b0, 64'd42, 1'b0, 1'b0, "post flush");
    drain("post flush");

    // Reset during a stall.
    out_rdy = 1'b0;
    send(64'd0, 54'd0, 1'b0, RNE, L, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "rst a");
    send(64'd9, HALF, 1'b0, RTZ, L, 1'b0, 1'b0, 64'd9, 1'b0, 1'b1, "rst b");
    cpurst = 1'b1;
    tick();
    check("rst stall out_vld", 64'(out_vld), 64'd0);
    check("rst stall out_result", out_result, 64'd0);
    check("rst stall out_nv", 64'(out_nv), 64'd0);
    check("rst stall out_nx", 64'(out_nx), 64'd0);
    cpurst  = 1'b0;
    check("rst stall in_rdy", 64'(in_rdy), 64'd1);
    out_rdy = 1'b1;
    repeat (3) tick();
    check("rst no stale", 64'(out_vld), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
